// File: rtl/idct_sink_pkg.sv
// Shared types and helpers for the IDCT block sink: FSM state enums,
// block geometry and the signed-field-to-pixel clamp.
package idct_sink_pkg;

  localparam int unsigned BLK_WORDS = 64;
  localparam int unsigned BLK_LOG2  = $clog2(BLK_WORDS);

  typedef enum logic [1:0] {
    C_IDLE,
    C_CAP,
    C_WAITLO
  } cap_state_e;

  typedef enum logic {
    D_IDLE,
    D_SEND
  } drn_state_e;

  // Saturate a sign-extended integer field into [0, 2^pix_w - 1].
  function automatic logic [31:0] clamp_field(input logic signed [31:0] f,
                                              input int unsigned       pix_w);
    logic signed [32:0] max_v;
    max_v = (33'sd1 <<< pix_w) - 33'sd1;
    if (f < 0) return '0;
    if ($signed({f[31], f}) > max_v) return 32'(max_v);
    return f;
  endfunction

endpackage

// File: rtl/idct_sink_bank.sv
// One ping-pong bank: single write port, registered single read port.
module idct_sink_bank
  import idct_sink_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned AW    = BLK_LOG2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem_q [0:(1<<AW)-1];
  logic [PIX_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  always_comb begin
    rdata = rdata_q;
  end

endmodule

// File: rtl/idct_block_sink.sv
// Captures 64-word IDCT blocks, clamps them to pixels into a ping-pong
// buffer and drains them over valid/ready. Optional IDCT_SINK_TRANSPOSE_EN
// drains each bank column-major to undo the IDCT's transposed output.
module idct_block_sink
  import idct_sink_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned FRAC  = 10,
  parameter int unsigned PIX_W = 8,
  parameter int unsigned BLK   = BLK_WORDS,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             done_in,
  input  logic [DW-1:0]    din,
  output logic [PIX_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             overflow,
  output logic             short_blk,
  output logic [CNT_W-1:0] blk_count
);

  localparam int unsigned AW   = $clog2(BLK);
  localparam logic [AW-1:0] LAST = AW'(BLK - 1);

  cap_state_e       cap_q, cap_d;
  drn_state_e       drn_q, drn_d;
  logic [AW-1:0]    wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic             wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [1:0]       full_q, full_d;
  logic             overflow_q, overflow_d, short_q, short_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;

  logic             we, cap_done, drain_done, bank_empty;
  logic [AW-1:0]    waddr, raddr;
  logic [PIX_W-1:0] pix;
  logic [PIX_W-1:0] rdata [2];
  logic             unused_frac;

  always_comb begin
    pix         = PIX_W'(clamp_field(32'($signed(din[DW-1:FRAC])), PIX_W));
    unused_frac = ^din[FRAC-1:0];
  end

  always_comb begin
    drain_done = (drn_q == D_SEND) && out_ready && (rcnt_q == LAST);
    // A bank being released this cycle is already free for a new capture.
    bank_empty = !full_q[wr_sel_q] || (drain_done && (rd_sel_q == wr_sel_q));
  end

  // Capture FSM
  always_comb begin
    cap_d      = cap_q;
    wcnt_d     = wcnt_q;
    wr_sel_d   = wr_sel_q;
    overflow_d = overflow_q;
    short_d    = short_q;
    we         = 1'b0;
    waddr      = '0;
    cap_done   = 1'b0;
    case (cap_q)
      C_IDLE: begin
        if (done_in) begin
          if (bank_empty) begin
            we     = 1'b1;
            wcnt_d = AW'(1);
            cap_d  = C_CAP;
          end else begin
            overflow_d = 1'b1;
            cap_d      = C_WAITLO;
          end
        end
      end
      C_CAP: begin
        if (done_in) begin
          we    = 1'b1;
          waddr = wcnt_q;
          if (wcnt_q == LAST) begin
            cap_done = 1'b1;
            wr_sel_d = ~wr_sel_q;
            cap_d    = C_WAITLO;
          end else begin
            wcnt_d = wcnt_q + AW'(1);
          end
        end else begin
          short_d = 1'b1;
          cap_d   = C_IDLE;
        end
      end
      C_WAITLO: begin
        if (!done_in) cap_d = C_IDLE;
      end
      default: cap_d = C_IDLE;
    endcase
  end

  always_comb begin
    full_d = full_q;
    if (drain_done) full_d[rd_sel_q] = 1'b0;
    if (cap_done)   full_d[wr_sel_q] = 1'b1;
  end

  // Drain FSM: read address tracks rcnt_d so the registered read lands
  // on the pixel presented next cycle.
  always_comb begin
    drn_d     = drn_q;
    rcnt_d    = rcnt_q;
    rd_sel_d  = rd_sel_q;
    blk_cnt_d = blk_cnt_q;
    case (drn_q)
      D_IDLE: begin
        rcnt_d = '0;
        if (full_q[rd_sel_q]) drn_d = D_SEND;
      end
      D_SEND: begin
        if (out_ready) begin
          if (rcnt_q == LAST) begin
            drn_d     = D_IDLE;
            rcnt_d    = '0;
            rd_sel_d  = ~rd_sel_q;
            blk_cnt_d = blk_cnt_q + CNT_W'(1);
          end else begin
            rcnt_d = rcnt_q + AW'(1);
          end
        end
      end
      default: drn_d = D_IDLE;
    endcase
`ifdef IDCT_SINK_TRANSPOSE_EN
    raddr = {rcnt_d[AW/2-1:0], rcnt_d[AW-1:AW/2]};
`else
    raddr = rcnt_d;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_q      <= C_IDLE;
      drn_q      <= D_IDLE;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      full_q     <= '0;
      overflow_q <= 1'b0;
      short_q    <= 1'b0;
      blk_cnt_q  <= '0;
    end else begin
      cap_q      <= cap_d;
      drn_q      <= drn_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      short_q    <= short_d;
      blk_cnt_q  <= blk_cnt_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    idct_sink_bank #(
      .PIX_W(PIX_W),
      .AW   (AW)
    ) u_bank (
      .clk  (clk),
      .rst_n(reset),
      .we   (we && (wr_sel_q == 1'(b))),
      .waddr(waddr),
      .wdata(pix),
      .raddr(raddr),
      .rdata(rdata[b])
    );
  end

  always_comb begin
    out_valid = (drn_q == D_SEND);
    out_last  = out_valid && (rcnt_q == LAST);
    out_data  = rdata[rd_sel_q];
    overflow  = overflow_q;
    short_blk = short_q;
    blk_count = blk_cnt_q;
  end

endmodule

// File: tb/tb_idct_block_sink.sv
// Scoreboard bench for idct_block_sink: block-level reference model feeds an
// expected-pixel queue that an independent monitor consumes on each handshake.
module tb_idct_block_sink;

  logic        clk = 1'b0;
  logic        reset, done_in, out_ready;
  logic [31:0] din;
  logic [7:0]  out_data;
  logic        out_valid, out_last, overflow, short_blk;
  logic [15:0] blk_count;

  always #5 clk = ~clk;

  idct_block_sink dut (
    .clk      (clk),
    .reset    (reset),
    .done_in  (done_in),
    .din      (din),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .overflow (overflow),
    .short_blk(short_blk),
    .blk_count(blk_count)
  );

  int          compared   = 0;
  int          mismatched = 0;
  int          hs_count   = 0;
  int          drained    = 0;
  int          accepted   = 0;
  int          ready_mode = 0;
  bit          exp_ovf    = 0;
  bit          exp_short  = 0;
  int unsigned exp_q[$];
  bit          explast_q[$];
  logic [31:0] blk_w [64];

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned clamp_ref(input logic [31:0] w);
    int f;
    f = $signed(w) >>> 10;
    if (f < 0)   return 0;
    if (f > 255) return 255;
    return f;
  endfunction

  function automatic int drain_index(input int k);
`ifdef IDCT_SINK_TRANSPOSE_EN
    return (k % 8) * 8 + k / 8;
`else
    return k;
`endif
  endfunction

  function automatic logic [31:0] mk_word(input int field);
    return 32'(field * 1024 + int'($urandom_range(0, 1023)));
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0) blk_w[i] = $urandom;
      else blk_w[i] = mk_word(int'($urandom_range(0, 700)) - 200);
    end
  endtask

  // Block-level model: a full block is kept while fewer than two are buffered.
  task automatic send_block(input int len);
    if (len >= 64) begin
      if (accepted - drained < 2) begin
        for (int k = 0; k < 64; k++) begin
          exp_q.push_back(clamp_ref(blk_w[drain_index(k)]));
          explast_q.push_back(k == 63);
        end
        accepted++;
      end else begin
        exp_ovf = 1'b1;
      end
    end else begin
      exp_short = 1'b1;
    end
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      done_in = 1'b1;
      din     = (i < 64) ? blk_w[i] : $urandom;
    end
    @(posedge clk); #1;
    done_in = 1'b0;
    din     = $urandom;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 5000) begin
      @(posedge clk);
      g++;
    end
    check("drain_complete", exp_q.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic check_quiet(input string tag);
    @(negedge clk);
    check({tag, "_valid_idle"}, out_valid, 0);
    check({tag, "_blk_count"}, blk_count, accepted % 65536);
    check({tag, "_overflow"}, overflow, exp_ovf);
    check({tag, "_short_blk"}, short_blk, exp_short);
  endtask

  initial begin
    int phase;
    phase     = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (phase == 0);
          phase     = (phase + 1) % 3;
        end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    bit          stall_prev;
    logic [9:0]  snap;
    int unsigned e;
    bit          l;
    stall_prev = 1'b0;
    snap       = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) check("stall_hold", {out_valid, out_last, out_data}, snap);
        if (out_valid && out_ready) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            check("unexpected_pixel", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            l = explast_q.pop_front();
            check("pixel", out_data, e);
            check("last", out_last, l);
            if (l) drained++;
          end
        end
        stall_prev = out_valid && !out_ready;
        snap       = {out_valid, out_last, out_data};
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, g, len, r;
    reset   = 1'b0;
    done_in = 1'b0;
    din     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_short_blk", short_blk, 0);
    check("rst_blk_count", blk_count, 0);
    reset = 1'b1;

    // Ramp
    ready_mode = 0;
    for (int i = 0; i < 64; i++) blk_w[i] = 32'(i) << 10;
    send_block(64);
    wait_drain();
    check_quiet("ramp");

    // Clamp corners
    fill_random();
    blk_w[0] = mk_word(-5);
    blk_w[1] = mk_word(0);
    blk_w[2] = mk_word(255);
    blk_w[3] = mk_word(300);
    send_block(64);
    wait_drain();
    check_quiet("clamp");

    // Backpressure 1,0,0
    ready_mode = 1;
    base = hs_count;
    fill_random();
    send_block(64);
    wait_drain();
    check("bp_handshakes", hs_count - base, 64);
    check_quiet("bp");

    // Overflow: two buffered, third dropped
    ready_mode = 3;
    for (int b = 0; b < 3; b++) begin
      fill_random();
      send_block(64);
      if (b == 1) check("ovf_before_third", overflow, 0);
    end
    @(negedge clk);
    check("ovf_after_third", overflow, 1);
    base = hs_count;
    ready_mode = 0;
    wait_drain();
    check("ovf_handshakes", hs_count - base, 128);
    check_quiet("ovf");

    // Short then long done
    fill_random();
    send_block(40);
    repeat (100) @(posedge clk);
    check_quiet("short");
    fill_random();
    send_block(70);
    wait_drain();
    check_quiet("long");

    // Random traffic
    ready_mode = 2;
    for (int b = 0; b < 16; b++) begin
      g = 0;
      while ((accepted - drained) >= 2 && g < 3000) begin
        @(posedge clk);
        g++;
      end
      if (g >= 3000) check("space_wait", accepted - drained, 1);
      fill_random();
      r = int'($urandom_range(0, 9));
      if (r == 0)      len = int'($urandom_range(1, 63));
      else if (r == 1) len = int'($urandom_range(65, 72));
      else             len = 64;
      repeat ($urandom_range(0, 5)) @(posedge clk);
      send_block(len);
    end
    wait_drain();
    check_quiet("random");

    // Reset mid-drain
    ready_mode = 0;
    fill_random();
    send_block(64);
    base = hs_count;
    g = 0;
    while (hs_count < base + 20 && g < 1000) begin
      @(posedge clk);
      g++;
    end
    check("reach_pixel20", hs_count - base >= 20, 1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_blk_count", blk_count, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_short_blk", short_blk, 0);
    exp_q.delete();
    explast_q.delete();
    accepted  = 0;
    drained   = 0;
    exp_ovf   = 1'b0;
    exp_short = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 64; i++) blk_w[i] = 32'(i) << 10;
    send_block(64);
    wait_drain();
    check_quiet("post_rst");

    check("leftover_expected", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/idct_block_sink.md
Name: idct_block_sink

Overview:
- Synthesizable consumer for the IDCT output stream.
- Captures one 8x8 block (64 words) each time the IDCT asserts done.
- Per word: extracts the integer pixel field, clamps it to 8-bit unsigned, and stores it in a ping-pong buffer.
- Drains each full block downstream over a valid/ready handshake, replacing the bench-only file writer on the IDCT output side.

Parameters:
- DW, 32, IDCT output word width.
- FRAC, 10, LSB index of the integer field (field = din[DW-1:FRAC], signed).
- PIX_W, 8, output pixel width.
- BLK, 64, words per block.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- done_in  in  1  IDCT done; one valid din per cycle while high.
- din  in  DW  IDCT output word.
- out_data  out  PIX_W  clamped pixel.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  high with the 64th pixel of a block.
- overflow  out  1  sticky: a block was dropped because both banks were full.
- short_blk  out  1  sticky: done fell before 64 words were captured.
- blk_count  out  CNT_W  number of blocks fully drained; wraps at 2^CNT_W.

Behaviour:
- Reset (async assert, sync release): all outputs 0, both banks empty, wr_sel=0, rd_sel=0, both FSMs idle.
- Clamp: f = signed din[DW-1:FRAC]; f<0 -> 0; f>2^PIX_W-1 -> 2^PIX_W-1; otherwise f[PIX_W-1:0].
- Storage: two banks, each BLK x PIX_W, each with a full flag.
- Capture FSM, states C_IDLE / C_CAP / C_WAITLO:
  - C_IDLE + done_in=1 + bank[wr_sel] empty: write word 0 in this cycle, wcnt=1, go to C_CAP.
  - C_IDLE + done_in=1 + bank[wr_sel] full: set overflow, go to C_WAITLO; the whole block is dropped.
  - C_CAP + done_in=1: write word at wcnt. When wcnt reaches BLK-1: set full[wr_sel], toggle wr_sel, go to C_WAITLO.
  - C_CAP + done_in=0 before 64 words: set short_blk, discard partial data (bank stays empty), go to C_IDLE.
  - C_WAITLO: ignore din (covers done held high beyond 64 cycles); done_in=0 -> C_IDLE.
- Drain FSM, states D_IDLE / D_SEND:
  - D_IDLE + full[rd_sel]: go to D_SEND. The first out_valid appears exactly 1 cycle after the full flag sets (registered read).
  - D_SEND: out_data/out_last hold stable while out_valid=1 and out_ready=0.
  - Each handshake (out_valid & out_ready) advances rcnt; next pixel is presented the following cycle, giving throughput of 1 pixel/cycle when ready is held high.
  - On the last handshake: clear full[rd_sel], toggle rd_sel, increment blk_count, drop out_valid for one cycle, return to D_IDLE.
- Simultaneous events:
  - A bank clearing in the same cycle a new capture starts on it counts as empty, so there is no overflow.
  - Capture completing and drain starting on different banks in the same cycle are independent.
- Latency: last captured word to first out_valid = 1 cycle when that bank is drained next.
- Sticky flags clear only on reset.
- Reset mid-block discards all buffered data.

Optional Feature:
- Macro: IDCT_SINK_TRANSPOSE_EN.
- Defined: drain reads the bank in column-major order, address = {rcnt[2:0], rcnt[5:3]}, undoing the IDCT transposed output.
- Undefined: drain reads in row-major order, address = rcnt.
- Handshake, latency and flags are identical in both builds.

Decomposition:
- Package idct_sink_pkg:
  - Capture and drain state enums.
  - BLK and log2(BLK) localparams.
  - Clamp function (signed field -> PIX_W).
- One sub-module, idct_sink_bank: 64 x PIX_W single-write/single-registered-read memory, instantiated twice.
- Both FSMs stay in the top level.

Test Plan:
- Ramp: done high 64 cycles, din = i<<10 for i=0..63, out_ready=1 -> out_data 0..63 in order, out_last on 63, blk_count=1.
- Clamp: din field values -5, 0, 255, 300 -> outputs 0, 0, 255, 255.
- Backpressure: out_ready toggles 1,0,0,1... -> out_data stable while stalled, no lost or duplicated pixel, exactly 64 handshakes.
- Overflow: out_ready=0, three back-to-back blocks -> blocks 1 and 2 buffered, overflow=1 on the third done rise; after release, 128 pixels matching blocks 1 and 2.
- Short/long done: done high 40 cycles -> short_blk=1, no output. Done high 70 cycles -> exactly 64 captured.
- Reset mid-drain: assert reset at pixel 20 -> out_valid=0 immediately, blk_count=0. After release, a new block drains correctly from pixel 0; with TRANSPOSE_EN the order is 0, 8, 16, ...
